mmio_timer: RTL and testbench

// - Memory-mapped timer device; the responder end of the M-stage data bus (addr/byteen/wdata in, rdata out).
// - Two instances sit behind the system bridge at 0x7F00 and 0x7F10. Each decodes a 16-byte window.
// - Counts down from a CPU-programmed preset and raises an interrupt request toward CP0.

---
 rtl/mmio_timer_pkg.sv | 41 ++++
 rtl/mmio_timer_byte_merge.sv | 25 ++
 rtl/mmio_timer.sv | 178 +++++++++++++++++
 tb/tb_mmio_timer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_pkg
// Description : Shared encodings for the memory-mapped countdown timer:
//               FSM states, register offsets, CTRL bit fields, timer modes.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_timer_pkg;

  // Timer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Word offsets within the 16-byte window (addr[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // CTRL register fields
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  // Timer modes; the unused encodings 1x behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Only the exact auto-reload encoding reloads; everything else is one-shot
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage : mmio_timer_pkg
`default_nettype wire

// File: rtl/mmio_timer_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : byte_merge
// Description : Per-byte-lane write merge. Each lane of the result takes the
//               new data when its byte enable is set, otherwise the old data.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] byteen,
  output logic [DATA_W-1:0]   merged
);

  localparam int LANES = DATA_W / 8;

  // One multiplexer per byte lane
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = byteen[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
  end

endmodule : byte_merge
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Memory-mapped countdown timer. CTRL/PRESET/COUNT registers in
//               a 16-byte window, a four-state sequencer that loads PRESET and
//               counts COUNT down to zero, and an interrupt request masked by
//               CTRL.IM. Reads are combinational; writes land on the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RSVD_RD = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [29:0]         addr,
  input  logic [DATA_W/8-1:0] byteen,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                irq
);

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  state_t              state;
  state_t              state_nxt;
  logic [CTRL_W-1:0]   ctrl;
  logic [DATA_W-1:0]   preset;
  logic [DATA_W-1:0]   count;
  logic                int_flag;

  // Sequencer outputs, computed from the pre-write register values
  logic [DATA_W-1:0]   count_nxt;
  logic                fsm_en_clear;
  logic                fsm_flag_set;
  logic                fsm_flag_ack;

  // Write decode and merged register images
  logic                wr_any;
  logic                wr_ctrl;
  logic                wr_preset;
  logic [CTRL_W-1:0]   ctrl_fsm;
  logic [DATA_W-1:0]   ctrl_merged;
  logic [DATA_W-1:0]   preset_merged;
  logic [CTRL_W-1:0]   ctrl_nxt;
  logic [DATA_W-1:0]   preset_nxt;
  logic                int_flag_nxt;

  logic                ctrl_en;
  logic [1:0]          ctrl_mode;

  assign ctrl_en   = ctrl[CTRL_EN];
  assign ctrl_mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

  // --------------------------------------------------------------------------
  // Write decode: only addr[3:2] selects a register; the bridge has already
  // qualified byteen with the device select.
  // --------------------------------------------------------------------------
  assign wr_any    = |byteen;
  assign wr_ctrl   = wr_any && (addr[1:0] == OFF_CTRL);
  assign wr_preset = wr_any && (addr[1:0] == OFF_PRESET);

  // Sequencer next state and the register effects it requests
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    fsm_en_clear = 1'b0;
    fsm_flag_set = 1'b0;
    fsm_flag_ack = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ctrl_en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          // Disabled mid-count: freeze COUNT where it is
          state_nxt = ST_IDLE;
        end else if (count > DATA_W'(1)) begin
          count_nxt = count - DATA_W'(1);
        end else begin
          // Terminal count (also covers PRESET=0); never wraps below zero
          count_nxt    = '0;
          fsm_flag_set = 1'b1;
          state_nxt    = ST_INT;
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_mode)) begin
          fsm_flag_ack = 1'b1;
        end else begin
          fsm_en_clear = 1'b1;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // CTRL as the sequencer leaves it, before any CPU write is layered on top
  always_comb begin
    ctrl_fsm = ctrl;
    if (fsm_en_clear) ctrl_fsm[CTRL_EN] = 1'b0;
  end

  // CPU writes merge over the sequencer's result, so written lanes win
  byte_merge #(.DATA_W(DATA_W)) u_merge_ctrl (
    .old_data (DATA_W'(ctrl_fsm)),
    .new_data (wdata),
    .byteen   (byteen),
    .merged   (ctrl_merged)
  );

  byte_merge #(.DATA_W(DATA_W)) u_merge_preset (
    .old_data (preset),
    .new_data (wdata),
    .byteen   (byteen),
    .merged   (preset_merged)
  );

  assign ctrl_nxt   = wr_ctrl   ? ctrl_merged[CTRL_W-1:0] : ctrl_fsm;
  assign preset_nxt = wr_preset ? preset_merged           : preset;

  // Interrupt flag: a terminal-count set beats a CPU-write clear
  always_comb begin
    int_flag_nxt = int_flag;
    if (fsm_flag_set) begin
      int_flag_nxt = 1'b1;
    end else if (wr_ctrl || wr_preset) begin
      int_flag_nxt = 1'b0;
    end else if (fsm_flag_ack) begin
      int_flag_nxt = 1'b0;
    end
  end

  // Register update; reset overrides both sequencer and CPU writes
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      int_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      int_flag <= int_flag_nxt;
    end
  end

  // Zero-latency read mux on addr[3:2]
  always_comb begin
    rdata = RSVD_RD;
    unique case (addr[1:0])
      OFF_CTRL:   rdata = DATA_W'(ctrl);
      OFF_PRESET: rdata = preset;
      OFF_COUNT:  rdata = count;
      OFF_RSVD:   rdata = RSVD_RD;
      default:    rdata = RSVD_RD;
    endcase
  end

  assign irq = int_flag & ctrl[CTRL_IM];

  // Address bits above the window and CTRL lanes beyond bit 3 carry no state
  logic unused_bits;
  assign unused_bits = ^{addr[29:2], ctrl_merged[DATA_W-1:CTRL_W]};

endmodule : mmio_timer
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_timer
// Description : Self-checking bench for mmio_timer. Directed scenarios plus
//               random bus traffic, every cycle compared against a behavioural
//               model of the timer kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_timer;

  localparam logic [31:0] RSVD = 32'hC0DE_0A5C;
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_CNT  = 2;
  localparam int P_INT  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  mmio_timer #(.DATA_W(32), .RSVD_RD(RSVD)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the timer's programmer-visible state
  logic [3:0]  m_ctrl   = '0;
  logic [31:0] m_preset = '0;
  logic [31:0] m_count  = '0;
  logic        m_flag   = 1'b0;
  int          m_phase  = P_IDLE;

  logic [31:0] obs_rdata;
  logic        obs_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] off);
    case (off)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return RSVD;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_flag & m_ctrl[3];
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge
  task automatic m_edge(input logic [29:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic r);
    bit en;
    bit fire;
    en   = m_ctrl[0];
    fire = 0;
    if (r) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE: if (en) m_phase = P_LOAD;
      P_LOAD: begin m_count = m_preset; m_phase = P_CNT; end
      P_CNT: begin
        if (!en) m_phase = P_IDLE;
        else if (m_count > 1) m_count = m_count - 1;
        else begin m_count = 0; fire = 1; m_phase = P_INT; end
      end
      default: begin
        if (m_ctrl[2:1] == 2'b01) m_flag = 1'b0;
        else m_ctrl[0] = 1'b0;
        m_phase = P_IDLE;
      end
    endcase
    if (be != 4'b0) begin
      if (a[1:0] == 2'd0) begin
        if (be[0]) m_ctrl = wd[3:0];
        m_flag = 1'b0;
      end else if (a[1:0] == 2'd1) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_preset[8*i +: 8] = wd[8*i +: 8];
        m_flag = 1'b0;
      end
    end
    if (fire) m_flag = 1'b1;
  endtask

  // One bus cycle: drive, compare outputs mid-cycle, then clock model and DUT
  task automatic drive(input logic [29:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic r);
    addr = a; byteen = be; wdata = wd; reset = r;
    @(negedge clk);
    obs_rdata = rdata;
    obs_irq   = irq;
    check("rdata", rdata, m_read(a[1:0]));
    check("irq", {31'd0, irq}, {31'd0, m_irq()});
    @(posedge clk);
    m_edge(a, be, wd, r);
    #1;
  endtask

  task automatic rd(input logic [1:0] off);
    drive({28'($urandom), off}, 4'b0000, $urandom, 1'b0);
  endtask

  task automatic wr(input logic [1:0] off, input logic [3:0] be, input logic [31:0] d);
    drive({28'($urandom), off}, be, d, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int last;
    int highs;
    int n;
    int r;
    logic [1:0]  off;
    logic [31:0] wd;

    reset = 1'b1; addr = '0; byteen = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values on every offset
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      check("rst_rd", obs_rdata, (i == 3) ? RSVD : 32'd0);
      check("rst_irq", {31'd0, obs_irq}, 32'd0);
    end

    // One-shot with interrupt enabled
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'hF, 32'h9);
    rise = -1;
    for (int k = 1; k <= 14; k++) begin
      rd(2'd2);
      if (k >= 3 && k <= 8) check("os_count", obs_rdata, 32'(8 - k));
      if (obs_irq && rise < 0) rise = k - 1;
    end
    check("os_irq_lat", rise, 32'd7);
    rd(2'd0);
    check("os_en_off", obs_rdata, 32'h8);
    check("os_irq_hold", {31'd0, obs_irq}, 32'd1);
    wr(2'd0, 4'hF, 32'h8);
    rd(2'd0);
    check("os_irq_clr", {31'd0, obs_irq}, 32'd0);

    // Auto-reload with interrupt enabled: one-cycle pulses every 6 cycles
    wr(2'd1, 4'hF, 32'd3);
    wr(2'd0, 4'hF, 32'hB);
    last = -1; highs = 0;
    for (int k = 1; k <= 30; k++) begin
      rd(2'd2);
      if (obs_irq) begin
        highs++;
        if (last >= 0) check("ar_period", 32'(k - last), 32'd6);
        last = k;
      end
    end
    check("ar_pulses", highs, 32'd5);
    // Same mode with IM cleared: irq must stay low
    wr(2'd0, 4'hF, 32'h3);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      rd(2'd2);
      if (obs_irq) highs++;
    end
    check("ar_no_im", highs, 32'd0);

    // Byte lanes and read-only COUNT
    wr(2'd0, 4'hF, 32'h0);
    repeat (3) rd(2'd2);
    wr(2'd1, 4'hF, 32'h11223344);
    wr(2'd1, 4'b0100, 32'hAABBCCDD);
    rd(2'd1);
    check("lane_merge", obs_rdata, 32'h11BB3344);
    wr(2'd2, 4'hF, 32'hFFFF_FFFF);
    rd(2'd2);
    check("count_ro", obs_rdata, m_count);

    // Disable mid-count, then re-enable and reload
    wr(2'd1, 4'hF, 32'd10);
    wr(2'd0, 4'hF, 32'h1);
    n = 0;
    rd(2'd2);
    while (obs_rdata != 32'd8 && n < 40) begin
      rd(2'd2);
      n++;
    end
    check("dis_reach", obs_rdata, 32'd8);
    wr(2'd0, 4'hF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      rd(2'd2);
      check("dis_hold", obs_rdata, 32'd6);
      check("dis_irq", {31'd0, obs_irq}, 32'd0);
    end
    wr(2'd0, 4'hF, 32'h1);
    rd(2'd2);
    rd(2'd2);
    rd(2'd2);
    check("dis_reload", obs_rdata, 32'd10);

    // CPU write to CTRL in the INT cycle wins over the one-shot EN clear
    wr(2'd0, 4'hF, 32'h0);
    repeat (3) rd(2'd2);
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'h1);
    n = 0;
    while (m_phase != P_INT && n < 20) begin
      rd(2'd2);
      n++;
    end
    check("coll_reach", m_phase, P_INT);
    wr(2'd0, 4'hF, 32'h1);
    rd(2'd0);
    check("coll_en", obs_rdata, 32'h1);
    rd(2'd2);
    rd(2'd2);
    check("coll_reload", obs_rdata, 32'd2);

    // Reset during CNT, with a simultaneous write that must be ignored
    wr(2'd1, 4'hF, 32'd20);
    wr(2'd0, 4'hF, 32'h9);
    repeat (5) rd(2'd2);
    drive({28'($urandom), 2'd1}, 4'hF, 32'h1234, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      check("rst_cnt_rd", obs_rdata, (i == 3) ? RSVD : 32'd0);
      check("rst_cnt_irq", {31'd0, obs_irq}, 32'd0);
    end

    // Random bus traffic against the model
    for (int i = 0; i < 500; i++) begin
      r   = $urandom_range(0, 99);
      off = 2'($urandom_range(0, 3));
      if (r < 2) begin
        drive({28'($urandom), off}, 4'($urandom), $urandom, 1'b1);
      end else if (r < 22) begin
        wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom;
        wr(off, 4'($urandom), wd);
      end else begin
        rd(off);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mmio_timer
`default_nettype wire
